// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, writeback port ids and the x0 address for the register-file writeback arbiter
package rf_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDRESS_WIDTH = 5;
  localparam int NUM_REGS = 32;
  localparam int X0_ADDR = 0;
  typedef enum logic {WB_ALU = 1'b0, WB_LSU = 1'b1} wb_port_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write bit vector with set-over-clear priority and RAW hazard lookup
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [ADDRESS_WIDTH-1:0] set_dest,
  input  logic                     clr_en,
  input  logic [ADDRESS_WIDTH-1:0] clr_dest,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs1,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs2,
  output logic [NUM_REGS-1:0]      busy,
  output logic                     hazard
);
  localparam logic [ADDRESS_WIDTH-1:0] X0 = ADDRESS_WIDTH'(X0_ADDR);
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  // x0 never enters either mask, so busy[0] can never be set
  always_comb begin
    set_mask = NUM_REGS'(set_en && set_dest != X0) << set_dest;
    clr_mask = NUM_REGS'(clr_en && clr_dest != X0) << clr_dest;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= (busy & ~clr_mask) | set_mask;
  assign hazard = busy[chk_rs1] | busy[chk_rs2];
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register-file write port between ALU and LSU writeback
// Scoreboard built only when RF_WB_SCOREBOARD_EN is defined; otherwise sb_busy/hazard are tied to 0.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb0_valid,
  input  logic [ADDRESS_WIDTH-1:0] wb0_dest,
  input  logic [DATA_WIDTH-1:0]    wb0_data,
  output logic                     wb0_ready,
  input  logic                     wb1_valid,
  input  logic [ADDRESS_WIDTH-1:0] wb1_dest,
  input  logic [DATA_WIDTH-1:0]    wb1_data,
  output logic                     wb1_ready,
  output logic                     rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data,
  input  logic                     sb_set_en,
  input  logic [ADDRESS_WIDTH-1:0] sb_set_dest,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs1,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs2,
  output logic                     hazard,
  output logic [NUM_REGS-1:0]      sb_busy
);
  localparam logic [ADDRESS_WIDTH-1:0] X0 = ADDRESS_WIDTH'(X0_ADDR);
  wb_port_e last_grant;
  logic grant_any;
  logic [ADDRESS_WIDTH-1:0] win_dest;
  logic [DATA_WIDTH-1:0] win_data;
  // ALU wins unless LSU is also requesting and the ALU took the previous grant
  always_comb begin
    wb0_ready = wb0_valid && (!wb1_valid || last_grant == WB_LSU);
    wb1_ready = wb1_valid && !wb0_ready;
    grant_any = wb0_ready || wb1_ready;
    win_dest = wb0_ready ? wb0_dest : wb1_dest;
    win_data = wb0_ready ? wb0_data : wb1_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_grant <= WB_LSU;
      rg_wrt_en <= 1'b0;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
    end else begin
      rg_wrt_en <= grant_any && win_dest != X0;
      if (grant_any) begin
        last_grant <= wb0_ready ? WB_ALU : WB_LSU;
        rg_wrt_dest <= win_dest;
        rg_wrt_data <= win_data;
      end
    end
`ifdef RF_WB_SCOREBOARD_EN
  rf_scoreboard #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .NUM_REGS(NUM_REGS)) u_sb (
    .clk(clk),
    .rst(rst),
    .set_en(sb_set_en),
    .set_dest(sb_set_dest),
    .clr_en(grant_any),
    .clr_dest(win_dest),
    .chk_rs1(chk_rs1),
    .chk_rs2(chk_rs2),
    .busy(sb_busy),
    .hazard(hazard)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set_en, sb_set_dest, chk_rs1, chk_rs2};
  assign sb_busy = '0;
  assign hazard = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for the writeback arbiter and scoreboard
module tb_rf_wb_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic wb0_valid = 1'b0, wb1_valid = 1'b0, wb0_ready, wb1_ready;
  logic [4:0] wb0_dest = '0, wb1_dest = '0;
  logic [31:0] wb0_data = '0, wb1_data = '0;
  logic rg_wrt_en, hazard;
  logic [4:0] rg_wrt_dest;
  logic [31:0] rg_wrt_data, sb_busy;
  logic sb_set_en = 1'b0;
  logic [4:0] sb_set_dest = '0, chk_rs1 = '0, chk_rs2 = '0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_dest(wb0_dest), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_dest(wb1_dest), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
    .sb_set_en(sb_set_en), .sb_set_dest(sb_set_dest),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard), .sb_busy(sb_busy)
  );

  task automatic test_reset;
    #2;
    n_cmp++; if (rg_wrt_en !== 1'b0) begin n_err++; $display("FAIL reset_en got %b want 0", rg_wrt_en); end
    n_cmp++; if (rg_wrt_dest !== 5'd0) begin n_err++; $display("FAIL reset_dest got %0d want 0", rg_wrt_dest); end
    n_cmp++; if (rg_wrt_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", rg_wrt_data); end
    n_cmp++; if (sb_busy !== 32'h0) begin n_err++; $display("FAIL reset_busy got %h want 0", sb_busy); end
    wb1_valid = 1'b1;
    #1;
    n_cmp++; if (wb1_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready1 got %b want 1", wb1_ready); end
    wb1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_alu;
    @(negedge clk);
    wb0_valid = 1'b1; wb0_dest = 5'd5; wb0_data = 32'hDEADBEEF;
    #1;
    n_cmp++; if ({wb0_ready, wb1_ready} !== 2'b10) begin n_err++; $display("FAIL single_ready got %b want 10", {wb0_ready, wb1_ready}); end
    @(posedge clk); #1;
    wb0_valid = 1'b0;
    n_cmp++; if ({rg_wrt_en, rg_wrt_dest, rg_wrt_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_err++; $display("FAIL single_write got en=%b dest=%0d data=%h want en=1 dest=5 data=deadbeef", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
    @(posedge clk); #1;
    n_cmp++; if (rg_wrt_en !== 1'b0) begin n_err++; $display("FAIL single_idle_en got %b want 0", rg_wrt_en); end
    n_cmp++; if ({rg_wrt_dest, rg_wrt_data} !== {5'd5, 32'hDEADBEEF}) begin n_err++; $display("FAIL single_hold got dest=%0d data=%h want dest=5 data=deadbeef", rg_wrt_dest, rg_wrt_data); end
  endtask

  task automatic test_round_robin;
    rst = 1'b1; #1; rst = 1'b0;
    @(negedge clk);
    wb0_valid = 1'b1; wb0_dest = 5'd3; wb0_data = 32'hA0A0_0003;
    wb1_valid = 1'b1; wb1_dest = 5'd4; wb1_data = 32'hB0B0_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({wb0_ready, wb1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_grant[%0d] got %b want %b", i, {wb0_ready, wb1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      @(posedge clk); #1;
      n_cmp++; if ({rg_wrt_en, rg_wrt_dest, rg_wrt_data} !== ((i % 2 == 0) ? {1'b1, 5'd3, 32'hA0A0_0003} : {1'b1, 5'd4, 32'hB0B0_0004})) begin n_err++; $display("FAIL rr_write[%0d] got en=%b dest=%0d data=%h", i, rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_scoreboard;
`ifdef RF_WB_SCOREBOARD_EN
    @(negedge clk);
    sb_set_en = 1'b1; sb_set_dest = 5'd7;
    @(posedge clk); #1;
    sb_set_en = 1'b0; chk_rs1 = 5'd7; chk_rs2 = 5'd0;
    #1;
    n_cmp++; if ({hazard, sb_busy} !== {1'b1, 32'h80}) begin n_err++; $display("FAIL sb_set got hazard=%b busy=%h want hazard=1 busy=00000080", hazard, sb_busy); end
    chk_rs1 = 5'd0; chk_rs2 = 5'd7; #1;
    n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL sb_rs2 got %b want 1", hazard); end
    chk_rs2 = 5'd3; #1;
    n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL sb_nohaz got %b want 0", hazard); end
    wb1_valid = 1'b1; wb1_dest = 5'd7; wb1_data = 32'h0000_0077; chk_rs1 = 5'd7;
    @(posedge clk); #1;
    wb1_valid = 1'b0;
    n_cmp++; if ({hazard, sb_busy, rg_wrt_en, rg_wrt_dest} !== {1'b0, 32'h0, 1'b1, 5'd7}) begin n_err++; $display("FAIL sb_clear got hazard=%b busy=%h en=%b dest=%0d want 0/0/1/7", hazard, sb_busy, rg_wrt_en, rg_wrt_dest); end
    wb1_valid = 1'b1; sb_set_en = 1'b1; sb_set_dest = 5'd7;
    @(posedge clk); #1;
    wb1_valid = 1'b0; sb_set_en = 1'b0;
    n_cmp++; if ({hazard, sb_busy} !== {1'b1, 32'h80}) begin n_err++; $display("FAIL sb_set_wins got hazard=%b busy=%h want 1/00000080", hazard, sb_busy); end
`else
    @(negedge clk);
    sb_set_en = 1'b1; sb_set_dest = 5'd9; chk_rs1 = 5'd9;
    @(posedge clk); #1;
    sb_set_en = 1'b0;
    n_cmp++; if ({hazard, sb_busy} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL sb_disabled got hazard=%b busy=%h want 0/0", hazard, sb_busy); end
`endif
  endtask

  task automatic test_x0;
    logic [31:0] exp_busy;
`ifdef RF_WB_SCOREBOARD_EN
    exp_busy = 32'h80;
`else
    exp_busy = 32'h0;
`endif
    @(negedge clk);
    wb1_valid = 1'b1; wb1_dest = 5'd0; wb1_data = 32'h1234;
    sb_set_en = 1'b1; sb_set_dest = 5'd0;
    #1;
    n_cmp++; if (wb1_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got %b want 1", wb1_ready); end
    @(posedge clk); #1;
    wb1_valid = 1'b0; sb_set_en = 1'b0;
    n_cmp++; if (rg_wrt_en !== 1'b0) begin n_err++; $display("FAIL x0_en got %b want 0", rg_wrt_en); end
    n_cmp++; if (sb_busy !== exp_busy) begin n_err++; $display("FAIL x0_busy got %h want %h", sb_busy, exp_busy); end
    chk_rs1 = 5'd0; chk_rs2 = 5'd0; #1;
    n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL x0_hazard got %b want 0", hazard); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    wb0_valid = 1'b1; wb0_dest = 5'd2; wb0_data = 32'h5;
    @(posedge clk); #1;
    wb0_valid = 1'b0;
    n_cmp++; if (rg_wrt_en !== 1'b1) begin n_err++; $display("FAIL mid_pre_en got %b want 1", rg_wrt_en); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({rg_wrt_en, rg_wrt_dest, rg_wrt_data, sb_busy} !== {1'b0, 5'd0, 32'h0, 32'h0}) begin n_err++; $display("FAIL mid_reset got en=%b dest=%0d data=%h busy=%h want all 0", rg_wrt_en, rg_wrt_dest, rg_wrt_data, sb_busy); end
    @(negedge clk);
    rst = 1'b0;
    wb0_valid = 1'b1; wb0_dest = 5'd3; wb1_valid = 1'b1; wb1_dest = 5'd4;
    #1;
    n_cmp++; if ({wb0_ready, wb1_ready} !== 2'b10) begin n_err++; $display("FAIL mid_first_tie got %b want 10", {wb0_ready, wb1_ready}); end
    @(posedge clk); #1;
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    n_cmp++; if ({rg_wrt_en, rg_wrt_dest} !== {1'b1, 5'd3}) begin n_err++; $display("FAIL mid_first_write got en=%b dest=%0d want 1/3", rg_wrt_en, rg_wrt_dest); end
  endtask

  initial begin
    test_reset;
    test_single_alu;
    test_round_robin;
    test_scoreboard;
    test_x0;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the register file's single write port between two writeback requesters: the ALU pipeline (port 0) and the load/store unit (port 1). It applies round-robin arbitration and registers the winning write into the register-file write interface. It also keeps a pending-write scoreboard, so issue logic can stall on read-after-write hazards. It sits between the execute/memory stages and the register file.

## Interface
- DATA_WIDTH, 32, bits per register
- ADDRESS_WIDTH, 5, register address width
- NUM_REGS, 32, number of registers and scoreboard bits
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- wb0_valid  in  1  ALU writeback request
- wb0_dest  in  ADDRESS_WIDTH  ALU destination register
- wb0_data  in  DATA_WIDTH  ALU result
- wb0_ready  out  1  ALU request granted this cycle
- wb1_valid / wb1_dest / wb1_data / wb1_ready  same as port 0, for the LSU
- rg_wrt_en  out  1  register-file write enable (registered)
- rg_wrt_dest  out  ADDRESS_WIDTH  register-file write address (registered)
- rg_wrt_data  out  DATA_WIDTH  register-file write data (registered)
- sb_set_en  in  1  issue stage marks a destination as pending
- sb_set_dest  in  ADDRESS_WIDTH  destination being marked
- chk_rs1, chk_rs2  in  ADDRESS_WIDTH  source registers of the instruction in issue
- hazard  out  1  chk_rs1 or chk_rs2 is pending (combinational)
- sb_busy  out  NUM_REGS  pending-write bit vector

## Operation
- Handshake is valid/ready.
  - A requester holds valid, dest and data stable until its ready is high.
  - Transfer happens when valid and ready are both high at a posedge.
  - Ready is combinational from the valids and the arbiter state.
- Arbitration:
  - One grant per cycle.
  - If only one port is valid, that port wins.
  - If both are valid, the port not granted last wins (round-robin). The last-grant flop updates only on a grant.
  - After reset, last-grant = 1, so port 0 wins the first tie.
- Output stage:
  - On a grant, rg_wrt_en/dest/data load the winner's values.
  - With no grant, rg_wrt_en = 0 and dest/data hold their previous values.
- x0 (dest = 0):
  - The request is granted and consumed.
  - rg_wrt_en stays 0.
  - The scoreboard is not touched.
- Scoreboard:
  - sb_set_en with a nonzero dest sets busy[dest].
  - A granted write with nonzero dest clears busy[dest] at the same edge.
  - If set and clear hit the same register in the same cycle, set wins (a newer producer is pending).
  - busy[0] is always 0.
  - hazard = busy[chk_rs1] | busy[chk_rs2].
  - A source of x0 never raises hazard.

## Timing
- Reset values:
  - rg_wrt_en = 0, rg_wrt_dest = 0, rg_wrt_data = 0.
  - sb_busy = 0, last-grant = 1.
  - wb0_ready and wb1_ready follow the valids immediately, because the arbiter is combinational.
- Latency:
  - Grant at edge N; rg_wrt_* are valid from N until N+1.
  - The register file writes on the negedge inside that cycle.
  - The new value is readable from that negedge on.
- Throughput is one write per cycle.
  - A port that loses a tie wins the next cycle if it is still valid.
  - Worst-case wait is 1 cycle.
- Reset mid-operation:
  - All state clears immediately.
  - A pending output write is dropped (rg_wrt_en = 0 asynchronously).
  - Requesters must re-present their requests after reset.
- Scoreboard timing:
  - A set at edge N is visible on hazard after edge N.
  - A clear at the grant edge N drops hazard after N.

## Configuration
- RF_WB_SCOREBOARD_EN defined:
  - The scoreboard is built as described above.
- RF_WB_SCOREBOARD_EN undefined:
  - No scoreboard flops.
  - sb_busy = 0 and hazard = 0 constantly.
  - sb_set_*, chk_rs1 and chk_rs2 are ignored.
  - Arbitration and the output stage are unchanged.

## Structure
- Package rf_pkg holds:
  - the defaults for DATA_WIDTH, ADDRESS_WIDTH and NUM_REGS;
  - typedef wb_port_e {WB_ALU = 0, WB_LSU = 1};
  - the x0 address constant.
- Sub-module rf_scoreboard holds:
  - the busy vector;
  - the set/clear priority;
  - the hazard lookup.
- rf_scoreboard is instantiated only under RF_WB_SCOREBOARD_EN.

## Test plan
- Reset then single ALU write: wb0 valid, dest 5, data 0xDEADBEEF.
  - Expect wb0_ready = 1 that cycle.
  - Next cycle: rg_wrt_en = 1, dest 5, data 0xDEADBEEF.
  - The following cycle: rg_wrt_en = 0.
- Both ports valid for 4 cycles (dest 3 and dest 4, each port raising valid again after every grant).
  - Expect grants ALU, LSU, ALU, LSU.
  - Writes to 3, 4, 3, 4 on consecutive cycles.
- Write to x0 with data 0x1234.
  - Expect ready = 1 and rg_wrt_en = 0 the next cycle.
  - Expect sb_busy unchanged.
- Scoreboard:
  - sb_set dest 7, then chk_rs1 = 7 → hazard = 1.
  - LSU write to dest 7 granted → hazard = 0 the next cycle.
  - sb_set dest 7 on the same cycle as the grant → busy[7] stays 1.
- Reset mid-operation: assert rst asynchronously while rg_wrt_en = 1 and sb_busy = 0x80.
  - Expect rg_wrt_en = 0 and sb_busy = 0 immediately.
  - After release, first tie goes to the ALU.
- Build without RF_WB_SCOREBOARD_EN: sb_set dest 9, chk_rs1 = 9.
  - Expect hazard = 0 and sb_busy = 0.
  - Arbitration results identical to the second scenario.
